// File: rtl/uart7n_pkg.sv
// Shared types and helpers for the UART7N echo path.
package uart7n_pkg;

  localparam int UART7N_DATA_W = 7;

  typedef enum logic [1:0] {
    IDLE,
    PULSE,
    WAIT_START,
    WAIT_DONE
  } echo_state_t;

  // Width of a counter that must hold the value n itself (0..n).
  function automatic int cnt_width(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/uart7n_echo_buffer_if.sv
// RX-side capture and TX-side handshake signals of the echo buffer.
interface uart7n_echo_buffer_if
  import uart7n_pkg::*;
#(
  parameter int p_data_width = UART7N_DATA_W,
  parameter int p_depth      = 8
);

  localparam int CNT_W = cnt_width(p_depth);

  logic [p_data_width-1:0] rx_data_i;
  logic                    rx_data_ready_i;
  logic                    rx_err_i;
  logic                    tx_busy_i;
  logic                    clr_flags_i;
  logic [p_data_width-1:0] tx_data_o;
  logic                    tx_enable_o;
  logic [CNT_W-1:0]        count_o;
  logic                    empty_o;
  logic                    full_o;
  logic                    overflow_o;
  logic                    err_drop_o;
  logic                    tx_timeout_o;

  modport slave (
    input  rx_data_i, rx_data_ready_i, rx_err_i, tx_busy_i, clr_flags_i,
    output tx_data_o, tx_enable_o, count_o, empty_o, full_o,
           overflow_o, err_drop_o, tx_timeout_o
  );

  modport master (
    output rx_data_i, rx_data_ready_i, rx_err_i, tx_busy_i, clr_flags_i,
    input  tx_data_o, tx_enable_o, count_o, empty_o, full_o,
           overflow_o, err_drop_o, tx_timeout_o
  );

endinterface

// File: rtl/uart7n_sync_fifo.sv
// Single-clock FIFO with registered read data; occupancy kept in its own counter.
module uart7n_sync_fifo
  import uart7n_pkg::*;
#(
  parameter int DATA_W = UART7N_DATA_W,
  parameter int DEPTH  = 8,
  localparam int CNT_W = cnt_width(DEPTH),
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      rdata  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
        rdata  <= mem[rd_ptr];
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart7n_echo_buffer.sv
// Echo-path buffer: captures good RX words into a FIFO and feeds UART TX one pulse per word.
module uart7n_echo_buffer
  import uart7n_pkg::*;
#(
  parameter int p_data_width    = UART7N_DATA_W,
  parameter int p_depth         = 8,
  parameter int p_start_timeout = 16
) (
  input logic                 clk_i,
  input logic                 rst_i,
  uart7n_echo_buffer_if.slave bus
);

  localparam int              CNT_W   = cnt_width(p_depth);
  localparam int              TO_W    = cnt_width(p_start_timeout);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(p_start_timeout - 1);

  echo_state_t      state;
  logic             rx_prev;
  logic             rx_rise;
  logic             push_req;
  logic             push;
  logic             pop;
  logic             to_set;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;
  logic             en_q;
  logic             err_drop_q;
  logic             overflow_q;
  logic             timeout_q;
  logic [TO_W-1:0]  to_cnt;

  assign rx_rise  = bus.rx_data_ready_i & ~rx_prev;
  assign push_req = rx_rise & ~bus.rx_err_i;
  assign pop      = (state == IDLE) & ~empty & ~bus.tx_busy_i;
  assign push     = push_req & (~full | pop);
  assign to_set   = (state == WAIT_START) & ~bus.tx_busy_i & (to_cnt == TO_LAST);

  uart7n_sync_fifo #(
    .DATA_W (p_data_width),
    .DEPTH  (p_depth)
  ) u_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (push),
    .pop   (pop),
    .wdata (bus.rx_data_i),
    .rdata (bus.tx_data_o),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  // Edge-detect register resets high so a level already asserted at reset release is ignored.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_prev    <= 1'b1;
      err_drop_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      rx_prev    <= bus.rx_data_ready_i;
      err_drop_q <= rx_rise & bus.rx_err_i;
      if (push_req & full & ~pop) begin
        overflow_q <= 1'b1;
      end else if (bus.clr_flags_i) begin
        overflow_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      en_q      <= 1'b0;
      to_cnt    <= '0;
      timeout_q <= 1'b0;
    end else begin
      en_q <= pop;
      case (state)
        IDLE: begin
          if (pop) begin
            state <= PULSE;
          end
        end
        PULSE: begin
          to_cnt <= '0;
          state  <= WAIT_START;
        end
        WAIT_START: begin
          if (bus.tx_busy_i) begin
            state <= WAIT_DONE;
          end else if (to_set) begin
            state <= IDLE;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        WAIT_DONE: begin
          if (!bus.tx_busy_i) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
      if (to_set) begin
        timeout_q <= 1'b1;
      end else if (bus.clr_flags_i) begin
        timeout_q <= 1'b0;
      end
    end
  end

  // Reset kills a pulse in the very cycle it is asserted.
  assign bus.tx_enable_o  = en_q & ~rst_i;
  assign bus.count_o      = count;
  assign bus.empty_o      = empty;
  assign bus.full_o       = full;
  assign bus.overflow_o   = overflow_q;
  assign bus.err_drop_o   = err_drop_q;
  assign bus.tx_timeout_o = timeout_q;

endmodule

// File: tb/tb_uart7n_echo_buffer.sv
// Directed bench for uart7n_echo_buffer with an echo scoreboard and a simple TX busy emulator.
module tb_uart7n_echo_buffer;

  localparam int DW = 7;
  localparam int DEPTH = 8;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic force_busy = 1'b0;
  logic emu_busy = 1'b0;
  logic emu_on = 1'b0;
  int   emu_hold = 3;
  logic prev_en = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;
  int   n_pulses = 0;
  logic [DW-1:0] exp_q[$];

  always #5 clk = ~clk;

  uart7n_echo_buffer_if #(.p_data_width(DW), .p_depth(DEPTH)) bus ();

  uart7n_echo_buffer #(
    .p_data_width    (DW),
    .p_depth         (DEPTH),
    .p_start_timeout (TO)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  assign bus.tx_busy_i = force_busy | emu_busy;

  // TX model: busy rises two cycles after a pulse and stays high emu_hold cycles.
  initial begin
    forever begin
      @(negedge clk);
      if (emu_on && bus.tx_enable_o === 1'b1) begin
        repeat (2) @(negedge clk);
        emu_busy = 1'b1;
        repeat (emu_hold) @(negedge clk);
        emu_busy = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    vectors++;
    assert (obs === want) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  // Advance one cycle; echoes are scored at the falling edge, inputs/checks happen #1 after the rising edge.
  task automatic tick();
    logic [DW-1:0] want;
    @(negedge clk);
    if (bus.tx_enable_o === 1'b1) begin
      n_pulses++;
      check("pulse_single_cycle", 32'(prev_en), 32'd0);
      check("pulse_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        want = exp_q.pop_front();
        check("echo_data", 32'(bus.tx_data_o), 32'(want));
      end
    end
    prev_en = bus.tx_enable_o;
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [DW-1:0] d, input logic e);
    bus.rx_data_i = d;
    bus.rx_err_i = e;
    bus.rx_data_ready_i = 1'b1;
    tick();
    bus.rx_data_ready_i = 1'b0;
    bus.rx_err_i = 1'b0;
    tick();
  endtask

  task automatic wait_idle(input string tag);
    int quiet = 0;
    int n = 0;
    while (quiet < 5 && n < 400) begin
      tick();
      n++;
      if (bus.tx_busy_i === 1'b0 && bus.empty_o === 1'b1 && bus.tx_enable_o === 1'b0)
        quiet++;
      else
        quiet = 0;
    end
    check(tag, 32'(quiet >= 5), 32'd1);
  endtask

  initial begin
    int base;
    bus.rx_data_i = '0;
    bus.rx_err_i = 1'b0;
    bus.rx_data_ready_i = 1'b1;
    bus.clr_flags_i = 1'b0;

    // Reset with data-ready already high.
    repeat (3) tick();
    check("rst_count", 32'(bus.count_o), 32'd0);
    check("rst_empty", 32'(bus.empty_o), 32'd1);
    check("rst_full", 32'(bus.full_o), 32'd0);
    check("rst_enable", 32'(bus.tx_enable_o), 32'd0);
    check("rst_flags", 32'({bus.overflow_o, bus.err_drop_o, bus.tx_timeout_o}), 32'd0);
    check("rst_txdata", 32'(bus.tx_data_o), 32'd0);
    rst = 1'b0;
    repeat (5) tick();
    check("t1_no_capture_count", 32'(bus.count_o), 32'd0);
    check("t1_no_capture_empty", 32'(bus.empty_o), 32'd1);
    check("t1_no_pulse", 32'(n_pulses), 32'd0);
    bus.rx_data_ready_i = 1'b0;
    tick();

    // Single word: write, pop, pulse in consecutive cycles.
    emu_on = 1'b1;
    emu_hold = 20;
    bus.rx_data_i = 7'h41;
    bus.rx_data_ready_i = 1'b1;
    exp_q.push_back(7'h41);
    tick();
    check("t2_cycle1_count", 32'(bus.count_o), 32'd1);
    check("t2_cycle1_no_en", 32'(bus.tx_enable_o), 32'd0);
    bus.rx_data_ready_i = 1'b0;
    tick();
    check("t2_latency_en", 32'(bus.tx_enable_o), 32'd1);
    check("t2_latency_data", 32'(bus.tx_data_o), 32'h41);
    check("t2_popped_count", 32'(bus.count_o), 32'd0);
    repeat (3) tick();
    exp_q.push_back(7'h42);
    send_word(7'h42, 1'b0);
    repeat (5) tick();
    check("t2_wait_busy_pulses", 32'(n_pulses), 32'd1);
    check("t2_wait_busy_count", 32'(bus.count_o), 32'd1);
    check("t2_data_held", 32'(bus.tx_data_o), 32'h41);
    wait_idle("t2_idle");
    check("t2_second_pulse", 32'(n_pulses), 32'd2);

    // Fill past capacity while TX is busy.
    emu_on = 1'b0;
    force_busy = 1'b1;
    base = n_pulses;
    for (int i = 1; i <= 8; i++) begin
      exp_q.push_back(DW'(i));
      send_word(DW'(i), 1'b0);
    end
    check("t3_full_count", 32'(bus.count_o), 32'd8);
    check("t3_full_flag", 32'(bus.full_o), 32'd1);
    check("t3_no_overflow_yet", 32'(bus.overflow_o), 32'd0);
    send_word(7'h09, 1'b0);
    check("t3_count_after_drop", 32'(bus.count_o), 32'd8);
    check("t3_overflow", 32'(bus.overflow_o), 32'd1);
    emu_on = 1'b1;
    emu_hold = 3;
    force_busy = 1'b0;
    wait_idle("t3_drain");
    repeat (10) tick();
    check("t3_pulses", 32'(n_pulses - base), 32'd8);
    check("t3_queue_drained", 32'(exp_q.size()), 32'd0);
    check("t3_overflow_sticky", 32'(bus.overflow_o), 32'd1);
    bus.clr_flags_i = 1'b1;
    tick();
    bus.clr_flags_i = 1'b0;
    check("t3_overflow_clr", 32'(bus.overflow_o), 32'd0);

    // Errored word is dropped with a one-cycle flag.
    force_busy = 1'b1;
    exp_q.push_back(7'h11);
    send_word(7'h11, 1'b0);
    base = n_pulses;
    bus.rx_data_i = 7'h55;
    bus.rx_err_i = 1'b1;
    bus.rx_data_ready_i = 1'b1;
    tick();
    check("t4_err_drop_pulse", 32'(bus.err_drop_o), 32'd1);
    check("t4_count_unchanged", 32'(bus.count_o), 32'd1);
    bus.rx_data_ready_i = 1'b0;
    bus.rx_err_i = 1'b0;
    tick();
    check("t4_err_drop_end", 32'(bus.err_drop_o), 32'd0);
    check("t4_count_still", 32'(bus.count_o), 32'd1);
    check("t4_no_pulse", 32'(n_pulses - base), 32'd0);
    force_busy = 1'b0;
    wait_idle("t4_idle");
    check("t4_only_good_sent", 32'(n_pulses - base), 32'd1);

    // TX never goes busy: timeout after the full WAIT_START window.
    emu_on = 1'b0;
    exp_q.push_back(7'h5A);
    bus.rx_data_i = 7'h5A;
    bus.rx_data_ready_i = 1'b1;
    tick();
    bus.rx_data_ready_i = 1'b0;
    tick();
    check("t5_pulse", 32'(bus.tx_enable_o), 32'd1);
    tick();
    repeat (TO - 1) tick();
    check("t5_not_yet", 32'(bus.tx_timeout_o), 32'd0);
    tick();
    check("t5_timeout", 32'(bus.tx_timeout_o), 32'd1);
    bus.clr_flags_i = 1'b1;
    tick();
    bus.clr_flags_i = 1'b0;
    check("t5_timeout_clr", 32'(bus.tx_timeout_o), 32'd0);
    emu_on = 1'b1;
    emu_hold = 3;
    base = n_pulses;
    exp_q.push_back(7'h66);
    send_word(7'h66, 1'b0);
    wait_idle("t5_back_to_idle");
    check("t5_resumed", 32'(n_pulses - base), 32'd1);

    // Full FIFO: push coincides with pop, then reset in WAIT_DONE.
    emu_on = 1'b0;
    force_busy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(DW'(8'h70 + i));
      send_word(DW'(8'h70 + i), 1'b0);
    end
    check("t6_full", 32'(bus.full_o), 32'd1);
    emu_on = 1'b1;
    emu_hold = 20;
    force_busy = 1'b0;
    bus.rx_data_i = 7'h78;
    bus.rx_data_ready_i = 1'b1;
    exp_q.push_back(7'h78);
    tick();
    bus.rx_data_ready_i = 1'b0;
    check("t6_count_same", 32'(bus.count_o), 32'd8);
    check("t6_no_overflow", 32'(bus.overflow_o), 32'd0);
    check("t6_pulse", 32'(bus.tx_enable_o), 32'd1);
    check("t6_head", 32'(bus.tx_data_o), 32'h70);
    repeat (4) tick();
    check("t6_waiting", 32'(bus.count_o), 32'd8);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_rst_count", 32'(bus.count_o), 32'd0);
    check("t6_rst_empty", 32'(bus.empty_o), 32'd1);
    check("t6_rst_enable", 32'(bus.tx_enable_o), 32'd0);
    exp_q.delete();
    base = n_pulses;
    wait_idle("t6_idle_after_rst");
    check("t6_no_pulse_after_rst", 32'(n_pulses - base), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
